// File: rtl/rvc_asap_5pl_vga_raster_pkg.sv
// Shared VGA timing constants and address helper for the raster block.
// The 640x480 frame is a 1-bit-per-pixel bitmap packed as 8 pixels x 4 lines per 32-bit word.
package rvc_asap_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [31:0] VGA_MEM_OFFSET = 32'h0000_3000;
    localparam logic [31:0] VGA_LINE_BYTES = 32'd320;

    // One word holds an 8x4 pixel tile, so a row of 80 tiles spans 4 scan lines.
    function automatic logic [31:0] vga_word_addr(input cnt_t h, input cnt_t v);
        return VGA_MEM_OFFSET + 32'(v >> 2) * VGA_LINE_BYTES + 32'(h >> 3) * 32'd4;
    endfunction

endpackage

// File: rtl/rvc_asap_5pl_vga_raster_if.sv
// Pixel-memory read port and video outputs of the raster block.
// Read timing: VgaRdAddr is held for a whole pixel period and VgaRdData must return the
// addressed word one Clock after the address is sampled; there is no valid/ready pairing.
interface rvc_asap_5pl_vga_raster_if;
    logic [31:0] VgaRdAddr;
    logic [31:0] VgaRdData;
    logic [3:0]  RED;
    logic [3:0]  GREEN;
    logic [3:0]  BLUE;
    logic        h_sync;
    logic        v_sync;
    logic        FrameStart;

    modport master (
        output VgaRdAddr, RED, GREEN, BLUE, h_sync, v_sync, FrameStart,
        input  VgaRdData
    );

    modport slave (
        input  VgaRdAddr, RED, GREEN, BLUE, h_sync, v_sync, FrameStart,
        output VgaRdData
    );
endinterface

// File: rtl/rvc_asap_5pl_vga_sync.sv
// Pixel-rate enable, horizontal/vertical counters, visible flag and raw (undelayed) syncs.
module rvc_asap_5pl_vga_sync
    import rvc_asap_pkg::*;
#(
    parameter int VIS_LINES   = V_VISIBLE,
    parameter int VFP_LINES   = V_FP,
    parameter int VSYNC_LINES = V_SYNC,
    parameter int VBP_LINES   = V_BP
) (
    input  logic Clock,
    input  logic Rst,
    output logic pixel_en,
    output cnt_t h_cnt,
    output cnt_t v_cnt,
    output logic visible,
    output logic h_sync_raw,
    output logic v_sync_raw,
    output logic frame_wrap
);

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
    localparam cnt_t HS_FIRST = cnt_t'(H_VISIBLE + H_FP);
    localparam cnt_t HS_LAST  = cnt_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam cnt_t V_LAST   = cnt_t'(VIS_LINES + VFP_LINES + VSYNC_LINES + VBP_LINES - 1);
    localparam cnt_t V_VIS    = cnt_t'(VIS_LINES);
    localparam cnt_t VS_FIRST = cnt_t'(VIS_LINES + VFP_LINES);
    localparam cnt_t VS_LAST  = cnt_t'(VIS_LINES + VFP_LINES + VSYNC_LINES - 1);

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Counters move on the second Clock of each pixel period, giving a 25 MHz pixel rate.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            pixel_en <= 1'b0;
            h_cnt    <= '0;
            v_cnt    <= '0;
        end else begin
            pixel_en <= ~pixel_en;
            if (pixel_en) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    assign visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign h_sync_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign v_sync_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    assign frame_wrap = pixel_en && h_last && v_last;

endmodule

// File: rtl/rvc_asap_5pl_vga_raster.sv
// VGA raster top: generates bitmap read addresses and registers colour/sync one pixel later.
module rvc_asap_5pl_vga_raster
    import rvc_asap_pkg::*;
#(
    parameter int VIS_LINES   = V_VISIBLE,
    parameter int VFP_LINES   = V_FP,
    parameter int VSYNC_LINES = V_SYNC,
    parameter int VBP_LINES   = V_BP
) (
    input  logic                          Clock,
    input  logic                          Rst,
    rvc_asap_5pl_vga_raster_if.master     vga
);

    logic        pixel_en;
    cnt_t        h_cnt;
    cnt_t        v_cnt;
    logic        visible;
    logic        h_sync_raw;
    logic        v_sync_raw;
    logic        frame_wrap;
    logic [31:0] rd_addr;
    logic        pix;
    logic [3:0]  rgb_q;
    logic        hs_q;
    logic        vs_q;
    logic        fs_q;

    rvc_asap_5pl_vga_sync #(
        .VIS_LINES   (VIS_LINES),
        .VFP_LINES   (VFP_LINES),
        .VSYNC_LINES (VSYNC_LINES),
        .VBP_LINES   (VBP_LINES)
    ) u_sync (
        .Clock      (Clock),
        .Rst        (Rst),
        .pixel_en   (pixel_en),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .visible    (visible),
        .h_sync_raw (h_sync_raw),
        .v_sync_raw (v_sync_raw),
        .frame_wrap (frame_wrap)
    );

    // Blanked pixels park the address on the bitmap base so memory sees a stable request.
    always_comb begin
        rd_addr = VGA_MEM_OFFSET;
        if (visible) begin
            rd_addr = vga_word_addr(h_cnt, v_cnt);
        end
    end

    assign pix = vga.VgaRdData[{v_cnt[1:0], h_cnt[2:0]}];

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            rgb_q <= 4'h0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            fs_q <= frame_wrap;
            if (pixel_en) begin
                rgb_q <= (visible && pix) ? 4'hF : 4'h0;
                hs_q  <= h_sync_raw;
                vs_q  <= v_sync_raw;
            end
        end
    end

    assign vga.VgaRdAddr  = rd_addr;
    assign vga.RED        = rgb_q;
    assign vga.GREEN      = rgb_q;
    assign vga.BLUE       = rgb_q;
    assign vga.h_sync     = hs_q;
    assign vga.v_sync     = vs_q;
    assign vga.FrameStart = fs_q;

endmodule

// File: tb/tb_rvc_asap_5pl_vga_raster.sv
// Bench for the VGA raster: behavioural frame model checked every Clock, plus literal anchors.
// Full horizontal timing is kept; the frame is shortened to 15 lines so whole frames fit the run.
module tb_rvc_asap_5pl_vga_raster;

    localparam int TB_VIS    = 8;
    localparam int TB_VFP    = 2;
    localparam int TB_VSYNC  = 2;
    localparam int TB_VBP    = 3;
    localparam int TB_VTOT   = TB_VIS + TB_VFP + TB_VSYNC + TB_VBP;
    localparam int FRAME_PIX = 800 * TB_VTOT;
    localparam int FRAME_CLK = 2 * FRAME_PIX;

    logic        Clock = 1'b0;
    logic        Rst   = 1'b1;
    int          mem_mode = 0;
    logic [31:0] seed = 32'h0;
    int          edges = 0;
    int          vectors = 0;
    int          miscompares = 0;

    rvc_asap_5pl_vga_raster_if vif ();

    rvc_asap_5pl_vga_raster #(
        .VIS_LINES   (TB_VIS),
        .VFP_LINES   (TB_VFP),
        .VSYNC_LINES (TB_VSYNC),
        .VBP_LINES   (TB_VBP)
    ) dut (
        .Clock (Clock),
        .Rst   (Rst),
        .vga   (vif)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #10 Clock = ~Clock;

    always @(posedge Clock or posedge Rst) begin
        if (Rst) edges <= 0;
        else     edges <= edges + 1;
    end

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (mem_mode)
            0:       return (a == 32'h3000) ? 32'h1 : 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return (a * 32'h9E37_79B1) ^ seed;
        endcase
    endfunction

    always @(posedge Clock) vif.VgaRdData <= mem_word(vif.VgaRdAddr);

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_addr(input int h, input int v);
        if (h < 640 && v < TB_VIS) return 32'h3000 + 32'(v / 4) * 32'd320 + 32'(h / 8) * 32'd4;
        return 32'h3000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t edges=%0d: got %h expected %h", name, $time, edges, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        int          cnt, idx, h, v;
        logic [31:0] e_addr, w;
        logic [3:0]  e_rgb;
        logic        e_hs, e_vs, e_fs;
        cnt    = (edges / 2) % FRAME_PIX;
        e_addr = model_addr(cnt % 800, cnt / 800);
        e_rgb  = 4'h0;
        e_hs   = 1'b1;
        e_vs   = 1'b1;
        e_fs   = 1'b0;
        if (!Rst && edges >= 2) begin
            idx   = (edges / 2 - 1) % FRAME_PIX;
            h     = idx % 800;
            v     = idx / 800;
            w     = mem_word(model_addr(h, v));
            if (h < 640 && v < TB_VIS && w[(v % 4) * 8 + (h % 8)]) e_rgb = 4'hF;
            e_hs  = !(h >= 656 && h <= 751);
            e_vs  = !(v >= TB_VIS + TB_VFP && v < TB_VIS + TB_VFP + TB_VSYNC);
            e_fs  = (edges % 2 == 0) && ((edges / 2) % FRAME_PIX == 0);
        end
        if (Rst) e_addr = 32'h3000;
        check("addr",   vif.VgaRdAddr,        e_addr);
        check("red",    32'(vif.RED),         32'(e_rgb));
        check("green",  32'(vif.GREEN),       32'(e_rgb));
        check("blue",   32'(vif.BLUE),        32'(e_rgb));
        check("hsync",  32'(vif.h_sync),      32'(e_hs));
        check("vsync",  32'(vif.v_sync),      32'(e_vs));
        check("fstart", 32'(vif.FrameStart),  32'(e_fs));
    end

    // ---------------- sync pulse measurement ----------------
    int   hs_since, hs_period, hs_low, vs_since, vs_low;
    logic hs_prev, vs_prev, hs_seen;

    always @(negedge Clock) begin
        if (Rst) begin
            hs_since = 0; hs_period = 0; hs_low = 0; hs_seen = 1'b0; hs_prev = 1'b1;
            vs_since = 0; vs_low = 0; vs_prev = 1'b1;
        end else begin
            hs_since++;
            vs_since++;
            if (hs_prev && !vif.h_sync) begin
                if (hs_seen) hs_period = hs_since;
                hs_seen  = 1'b1;
                hs_since = 0;
            end
            if (!hs_prev && vif.h_sync) hs_low = hs_since;
            if (vs_prev && !vif.v_sync) vs_since = 0;
            if (!vs_prev && vif.v_sync) vs_low = vs_since;
            hs_prev = vif.h_sync;
            vs_prev = vif.v_sync;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_frame_start(input string name);
        int k;
        k = 0;
        do begin
            @(negedge Clock);
            k++;
        end while (!vif.FrameStart && k < FRAME_CLK + 5000);
        check(name, 32'(k), 32'(FRAME_CLK));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"}, vif.VgaRdAddr,       32'h3000);
        check({tag, "_rgb"},  32'({vif.RED, vif.GREEN, vif.BLUE}), 32'h0);
        check({tag, "_hs"},   32'(vif.h_sync),     32'h1);
        check({tag, "_vs"},   32'(vif.v_sync),     32'h1);
        check({tag, "_fs"},   32'(vif.FrameStart), 32'h0);
    endtask

    initial begin
        int r, hp, n;
        seed     = $urandom;
        mem_mode = 0;
        Rst      = 1'b1;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check_reset_values("reset");
        Rst = 1'b0;

        // single lit pixel at word 0x3000, bit 0
        for (int k = 1; k <= 8500; k++) begin
            @(negedge Clock);
            if (k == 2)    check("pix_0_0_red", 32'(vif.RED), 32'hF);
            if (k == 4)    check("pix_1_0_red", 32'(vif.RED), 32'h0);
            if (k == 8018) check("addr_9_5",    vif.VgaRdAddr, 32'h3144);
        end
        check("hs_period", 32'(hs_period), 32'd1600);
        check("hs_low",    32'(hs_low),    32'd192);

        // all-ones bitmap: blanking must still force black
        @(negedge Clock);
        #2 Rst = 1'b1;
        mem_mode = 1;
        repeat (3) @(negedge Clock);
        Rst = 1'b0;
        wait_frame_start("frame_after_reset1");
        check("vs_low", 32'(vs_low), 32'd3200);

        // random visible pixel, then an asynchronous mid-frame reset
        r  = $urandom_range(1, 6);
        hp = $urandom_range(100, 600);
        n  = 2 * (r * 800 + hp) + 2;
        repeat (n) @(negedge Clock);
        check("pre_reset_red", 32'(vif.RED), 32'hF);
        #2 Rst = 1'b1;
        #1 check_reset_values("async_reset");
        mem_mode = 2;
        repeat (4) @(negedge Clock);
        Rst = 1'b0;
        wait_frame_start("frame_after_reset2");
        repeat (20) @(negedge Clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rvc_asap_5pl_vga_raster.md
RVC_ASAP_5PL_VGA_RASTER -- requirements
Module: rvc_asap_5pl_vga_raster

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-high; ports are named Clock and Rst.
REQ-002 Clock SHALL be a 1-bit input: the 50 MHz core clock.
REQ-003 Rst SHALL be a 1-bit input: asynchronous, active-high reset.
REQ-004 VgaRdAddr SHALL be a 32-bit output: word-aligned byte address into the VGA memory.
REQ-005 VgaRdData SHALL be a 32-bit input: read data, valid one Clock after VgaRdAddr is sampled.
REQ-006 RED, GREEN and BLUE SHALL each be 4-bit outputs: pixel colour.
REQ-007 h_sync SHALL be a 1-bit output: horizontal sync, active-low.
REQ-008 v_sync SHALL be a 1-bit output: vertical sync, active-low.
REQ-009 FrameStart SHALL be a 1-bit output: a one-Clock pulse when the counters wrap to (0,0).

Function
REQ-010 PixelEn SHALL be an internal toggle: 0 after reset, inverting every Clock, so one pixel period is 2 Clocks (25 MHz).
REQ-011 HCnt (0..799) SHALL advance only on Clocks where PixelEn=1.
- HCnt wraps 799->0.
- VCnt (0..524) increments when HCnt wraps.
- VCnt wraps 524->0 when HCnt wraps at VCnt=524.
REQ-012 Horizontal timing SHALL be: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-013 Vertical timing SHALL be: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-014 VgaRdAddr SHALL be derived combinationally from the registered counters, so it is stable for the full pixel period.
- VgaRdAddr = 0x3000 + (VCnt>>2)*320 + (HCnt>>3)*4.
- Only the visible region is addressed; outside it, VgaRdAddr = 0x3000.
REQ-015 On each PixelEn=1 Clock, the block SHALL register the outputs for the current (HCnt,VCnt), before the counters advance.
- Byte select = VCnt[1:0].
- Bit select = HCnt[2:0].
- pix = VgaRdData[8*VCnt[1:0] + HCnt[2:0]].
REQ-016 Output latency SHALL be one pixel period (2 Clocks) after the counter value.
- h_sync and v_sync are delayed identically, so sync and RGB stay aligned.
REQ-017 In the visible region, RED/GREEN/BLUE SHALL be 4'hF when pix=1 and 4'h0 otherwise.
- Outside the visible region, RGB is forced to 4'h0 regardless of VgaRdData.
REQ-018 h_sync SHALL be 0 exactly while the delayed HCnt is in 656..751; v_sync SHALL be 0 exactly while the delayed VCnt is in 490..491.
REQ-019 FrameStart SHALL pulse on the Clock on which the counters wrap (799,524)->(0,0).
REQ-020 All arithmetic SHALL be unsigned.
- HCnt and VCnt are 10-bit.
- Address math is done in 32 bits with no truncation.
- Maximum address is 0x3000 + 119*320 + 79*4 = 0x3000 + 0x95FC.

Reset
REQ-021 While Rst=1, all registers SHALL hold their reset values:
- PixelEn=0, HCnt=0, VCnt=0.
- RED/GREEN/BLUE=0.
- h_sync=1, v_sync=1, FrameStart=0.
- VgaRdAddr=0x3000.
REQ-022 Rst asserted mid-frame SHALL return the outputs to their reset values immediately (asynchronously).
- After release, the first line starts at (0,0) with no partial sync pulse.

Structure
REQ-023 The timing constants SHALL live in rvc_asap_pkg: H_VISIBLE, H_FP, H_SYNC, H_BP, H_TOTAL, V_VISIBLE, V_FP, V_SYNC, V_BP, V_TOTAL, VGA_MEM_OFFSET=0x3000, VGA_LINE_BYTES=320.
REQ-024 PixelEn, HCnt, VCnt, the visible flag and raw sync generation SHALL be in one sub-module, rvc_asap_5pl_vga_sync.
- rvc_asap_5pl_vga_raster instantiates rvc_asap_5pl_vga_sync.
- rvc_asap_5pl_vga_raster owns address generation, bit select and the output registers.

Verification
REQ-025 Reset check: hold Rst for 4 Clocks, then release -> during reset, RGB=0, h_sync=v_sync=1, VgaRdAddr=0x3000, FrameStart=0.
REQ-026 Horizontal timing: run 2 lines -> h_sync period is 1600 Clocks, low for 192 Clocks, and the falling edge occurs 2 Clocks after HCnt reaches 656.
REQ-027 Vertical timing: run 2 frames -> FrameStart period is 840000 Clocks, and v_sync is low for 3200 Clocks.
REQ-028 Pixel mapping: memory model returns 0x00000001 for word 0x3000 -> pixel (0,0) is RGB 4'hF and (1,0) is 0.
- At (9,5), VgaRdAddr = 0x3144, and bit 9 of the returned word drives the pixel.
REQ-029 Blanking: VgaRdData held at 0xFFFFFFFF -> RGB is 4'hF for delayed HCnt 0..639 and 0 for 640..799, and 0 for all of lines 480..524.
REQ-030 Mid-frame reset: assert Rst at VCnt=200, HCnt=300 -> outputs go to reset values that same Clock; after release, the next FrameStart arrives exactly 840000 Clocks later.
